// File: rtl/unidad_carga_almacen.sv
// rtl/unidad_carga_almacen.sv - load/store unit in front of the big-endian MemDatos memory
// Sub-word stores use read-modify-write; faulty accesses finish without touching memory.
module unidad_carga_almacen #(
  parameter int TAM_MEM = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [2:0]  Op,
  input  logic [31:0] Dir,
  input  logic [31:0] DatoE,
  output logic        Ocupado,
  output logic        Listo,
  output logic        Error,
  output logic [31:0] DatoCarga,
  output logic [31:0] MemDir,
  output logic [31:0] MemDatoE,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] MemDatoS
);

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;
  localparam logic [31:0] L_PALABRAS = 32'(TAM_MEM / 4);

  typedef enum logic [2:0] {INACTIVO, LEER, LEER_RMW, ESCRIBIR, FIN} estado_t;

  estado_t     r_estado;
  logic [2:0]  r_op;
  logic [1:0]  r_off;
  logic [15:0] r_dato;

  logic        w_desal;
  logic        w_fuera;
  logic        w_error;
  logic [7:0]  w_byte;
  logic [15:0] w_media;
  logic [31:0] w_carga;
  logic [31:0] w_fusion;

  assign Ocupado = (r_estado != INACTIVO);

  always_comb begin
    w_desal = 1'b0;
    case (Op)
      OP_LH, OP_LHU, OP_SH: w_desal = Dir[0];
      OP_LW, OP_SW:         w_desal = |Dir[1:0];
      default:              w_desal = 1'b0;
    endcase
  end

  assign w_fuera = ({2'b00, Dir[31:2]} >= L_PALABRAS);
  assign w_error = w_desal | w_fuera;

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    w_byte = MemDatoS[7:0];
    case (r_off)
      2'd0:    w_byte = MemDatoS[31:24];
      2'd1:    w_byte = MemDatoS[23:16];
      2'd2:    w_byte = MemDatoS[15:8];
      default: w_byte = MemDatoS[7:0];
    endcase
  end

  assign w_media = r_off[1] ? MemDatoS[15:0] : MemDatoS[31:16];

  always_comb begin
    w_carga = MemDatoS;
    case (r_op)
      OP_LB:   w_carga = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_carga = {24'd0, w_byte};
      OP_LH:   w_carga = {{16{w_media[15]}}, w_media};
      OP_LHU:  w_carga = {16'd0, w_media};
      default: w_carga = MemDatoS;
    endcase
  end

  always_comb begin
    w_fusion = MemDatoS;
    if (r_op == OP_SB) begin
      case (r_off)
        2'd0:    w_fusion[31:24] = r_dato[7:0];
        2'd1:    w_fusion[23:16] = r_dato[7:0];
        2'd2:    w_fusion[15:8]  = r_dato[7:0];
        default: w_fusion[7:0]   = r_dato[7:0];
      endcase
    end else if (r_off[1]) begin
      w_fusion[15:0] = r_dato;
    end else begin
      w_fusion[31:16] = r_dato;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado  <= INACTIVO;
      r_op      <= 3'd0;
      r_off     <= 2'd0;
      r_dato    <= 16'd0;
      Listo     <= 1'b0;
      Error     <= 1'b0;
      DatoCarga <= 32'd0;
      MemDir    <= 32'd0;
      MemDatoE  <= 32'd0;
      MemWrite  <= 1'b0;
      MemRead   <= 1'b0;
    end else begin
      case (r_estado)
        INACTIVO: begin
          if (Req) begin
            r_op   <= Op;
            r_off  <= Dir[1:0];
            r_dato <= DatoE[15:0];
            if (w_error) begin
              r_estado <= FIN;
              Listo    <= 1'b1;
              Error    <= 1'b1;
            end else begin
              MemDir <= {Dir[31:2], 2'b00};
              if (Op == OP_SW) begin
                r_estado <= ESCRIBIR;
                MemDatoE <= DatoE;
                MemWrite <= 1'b1;
              end else if (Op == OP_SB || Op == OP_SH) begin
                r_estado <= LEER_RMW;
                MemRead  <= 1'b1;
              end else begin
                r_estado <= LEER;
                MemRead  <= 1'b1;
              end
            end
          end
        end
        LEER: begin
          DatoCarga <= w_carga;
          MemRead   <= 1'b0;
          Listo     <= 1'b1;
          r_estado  <= FIN;
        end
        LEER_RMW: begin
          MemDatoE <= w_fusion;
          MemRead  <= 1'b0;
          MemWrite <= 1'b1;
          r_estado <= ESCRIBIR;
        end
        ESCRIBIR: begin
          MemWrite <= 1'b0;
          Listo    <= 1'b1;
          r_estado <= FIN;
        end
        default: begin
          Listo    <= 1'b0;
          Error    <= 1'b0;
          r_estado <= INACTIVO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_carga_almacen.sv
// tb/tb_unidad_carga_almacen.sv - self-checking bench for unidad_carga_almacen
// A behavioural big-endian memory sits behind the unit; expectations go through a queue.
module tb_unidad_carga_almacen;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [2:0]  Op;
  logic [31:0] Dir;
  logic [31:0] DatoE;
  logic        Ocupado, Listo, Error, MemWrite, MemRead;
  logic [31:0] DatoCarga, MemDir, MemDatoE, MemDatoS;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  unidad_carga_almacen #(.TAM_MEM(256)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Op(Op), .Dir(Dir), .DatoE(DatoE),
    .Ocupado(Ocupado), .Listo(Listo), .Error(Error), .DatoCarga(DatoCarga),
    .MemDir(MemDir), .MemDatoE(MemDatoE), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemDatoS(MemDatoS)
  );

  assign MemDatoS = mem[MemDir[7:2]];
  always @(posedge clk) if (MemWrite) mem[MemDir[7:2]] <= MemDatoE;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] dato;
    int          nrd;
    int          nwr;
    logic [31:0] wdat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          o_lat, o_nrd, o_nwr, o_both;
  logic        o_err;
  logic [31:0] o_dato, o_wdat, o_dir;

  // Drives one request from a falling edge and records what the unit does until Listo.
  task automatic issue(input logic [2:0] op, input logic [31:0] dir, input logic [31:0] dato);
    Req = 1'b1; Op = op; Dir = dir; DatoE = dato;
    o_lat = 0; o_nrd = 0; o_nwr = 0; o_both = 0; o_err = 1'bx; o_dato = 'x; o_wdat = 'x; o_dir = 'x;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) Req = 1'b0;
      if (MemRead && MemWrite) o_both++;
      if (MemRead) begin o_nrd++; o_dir = MemDir; end
      if (MemWrite) begin o_nwr++; o_wdat = MemDatoE; o_dir = MemDir; end
      if (Listo) begin
        o_lat = c; o_err = Error; o_dato = DatoCarga;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; Req = 1'b0; Op = 3'd0; Dir = 32'd0; DatoE = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({Listo, Error, MemWrite, MemRead, Ocupado} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000", {Listo, Error, MemWrite, MemRead, Ocupado});
    end
    n_cmp++;
    if (DatoCarga !== 32'd0 || MemDir !== 32'd0 || MemDatoE !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", DatoCarga, MemDir, MemDatoE);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  ops  [5] = '{LB, LBU, LH, LHU, LW};
    logic [31:0] dirs [5] = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10};
    logic [31:0] exps [5] = '{32'hFFFFFFF4, 32'h000000F4, 32'hFFFF8122, 32'h000033F4, 32'h812233F4};
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back('{lat: 2, err: 1'b0, dato: exps[i], nrd: 1, nwr: 0, wdat: 32'h0});
      issue(ops[i], dirs[i], 32'h0);
      e = sb_q.pop_front();
      n_cmp++;
      if (o_lat !== e.lat || o_err !== e.err) begin
        n_bad++;
        $display("FAIL load%0d_timing: got lat=%0d err=%b expected lat=%0d err=%b", i, o_lat, o_err, e.lat, e.err);
      end
      n_cmp++;
      if (o_dato !== e.dato) begin
        n_bad++;
        $display("FAIL load%0d_data: got %h expected %h", i, o_dato, e.dato);
      end
      n_cmp++;
      if (o_nrd !== e.nrd || o_nwr !== e.nwr || o_dir !== 32'h10 || o_both !== 0) begin
        n_bad++;
        $display("FAIL load%0d_strobes: got rd=%0d wr=%0d dir=%h both=%0d expected rd=1 wr=0 dir=10 both=0",
                 i, o_nrd, o_nwr, o_dir, o_both);
      end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  ops  [6] = '{SB, LW, SH, LW, SW, LW};
    logic [31:0] dirs [6] = '{32'h11, 32'h10, 32'h12, 32'h10, 32'h14, 32'h14};
    logic [31:0] dats [6] = '{32'h000000AB, 32'h0, 32'h0000BEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    exp_t e;
    sb_q.push_back('{lat: 3, err: 1'b0, dato: 32'h812233F4, nrd: 1, nwr: 1, wdat: 32'h81AB33F4});
    sb_q.push_back('{lat: 2, err: 1'b0, dato: 32'h81AB33F4, nrd: 1, nwr: 0, wdat: 32'h0});
    sb_q.push_back('{lat: 3, err: 1'b0, dato: 32'h81AB33F4, nrd: 1, nwr: 1, wdat: 32'h81ABBEEF});
    sb_q.push_back('{lat: 2, err: 1'b0, dato: 32'h81ABBEEF, nrd: 1, nwr: 0, wdat: 32'h0});
    sb_q.push_back('{lat: 2, err: 1'b0, dato: 32'h81ABBEEF, nrd: 0, nwr: 1, wdat: 32'hDEADBEEF});
    sb_q.push_back('{lat: 2, err: 1'b0, dato: 32'hDEADBEEF, nrd: 1, nwr: 0, wdat: 32'h0});
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], dirs[i], dats[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (o_lat !== e.lat || o_err !== e.err || o_dato !== e.dato) begin
        n_bad++;
        $display("FAIL store%0d_result: got lat=%0d err=%b dato=%h expected lat=%0d err=%b dato=%h",
                 i, o_lat, o_err, o_dato, e.lat, e.err, e.dato);
      end
      n_cmp++;
      if (o_nrd !== e.nrd || o_nwr !== e.nwr || o_both !== 0 || (e.nwr == 1 && o_wdat !== e.wdat)) begin
        n_bad++;
        $display("FAIL store%0d_mem: got rd=%0d wr=%0d wdat=%h expected rd=%0d wr=%0d wdat=%h",
                 i, o_nrd, o_nwr, o_wdat, e.nrd, e.nwr, e.wdat);
      end
    end
  endtask

  task automatic test_errors;
    logic [2:0]  ops  [4] = '{LW, SH, SW, LB};
    logic [31:0] dirs [4] = '{32'h11, 32'h13, 32'h100, 32'h104};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{lat: 1, err: 1'b1, dato: 32'hDEADBEEF, nrd: 0, nwr: 0, wdat: 32'h0});
      issue(ops[i], dirs[i], 32'h12345678);
      e = sb_q.pop_front();
      n_cmp++;
      if (o_lat !== e.lat || o_err !== e.err || o_dato !== e.dato || o_nrd !== 0 || o_nwr !== 0) begin
        n_bad++;
        $display("FAIL error%0d: got lat=%0d err=%b dato=%h rd=%0d wr=%0d expected lat=1 err=1 dato=%h rd=0 wr=0",
                 i, o_lat, o_err, o_dato, o_nrd, o_nwr, e.dato);
      end
    end
    n_cmp++;
    if (Error !== 1'b0 || Listo !== 1'b0) begin
      n_bad++;
      $display("FAIL error_clear: got err=%b listo=%b expected 0/0", Error, Listo);
    end
  endtask

  task automatic test_reset_mid;
    int nlisto;
    Req = 1'b1; Op = SB; Dir = 32'h15; DatoE = 32'h00000077;
    @(negedge clk);
    Req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (MemWrite !== 1'b1) begin
      n_bad++;
      $display("FAIL rmw_write_phase: got MemWrite=%b expected 1", MemWrite);
    end
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (MemWrite !== 1'b0 || MemRead !== 1'b0 || Ocupado !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got wr=%b rd=%b ocupado=%b expected 0/0/0", MemWrite, MemRead, Ocupado);
    end
    @(negedge clk);
    reset = 1'b0;
    nlisto = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (Listo) nlisto++;
    end
    n_cmp++;
    if (nlisto !== 0 || mem[5] !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL reset_abandon: got listo=%0d word=%h expected listo=0 word=deadbeef", nlisto, mem[5]);
    end
  endtask

  task automatic test_busy_req;
    int nlisto, nwr;
    Req = 1'b1; Op = LW; Dir = 32'h10; DatoE = 32'h0;
    nlisto = 0; nwr = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (Listo) nlisto++;
      if (MemWrite) nwr++;
      if (c == 1) begin Req = 1'b1; Op = SW; Dir = 32'h14; DatoE = 32'h0BADF00D; end
      if (c == 2) Req = 1'b0;
    end
    n_cmp++;
    if (nlisto !== 1 || nwr !== 0 || mem[5] !== 32'hDEADBEEF || DatoCarga !== 32'h81ABBEEF) begin
      n_bad++;
      $display("FAIL busy_ignore: got listo=%0d wr=%0d word=%h dato=%h expected 1/0/deadbeef/81abbeef",
               nlisto, nwr, mem[5], DatoCarga);
    end
  endtask

  task automatic test_back_to_back;
    int exp_c[$];
    int got_c[$];
    exp_c.push_back(2);
    exp_c.push_back(5);
    Req = 1'b1; Op = LHU; Dir = 32'h10; DatoE = 32'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (Listo) begin
        got_c.push_back(c);
        n_cmp++;
        if (DatoCarga !== 32'h000081AB) begin
          n_bad++;
          $display("FAIL b2b_data: got %h expected 000081ab", DatoCarga);
        end
      end
      if (c == 5) Req = 1'b0;
    end
    n_cmp++;
    if (got_c.size() != 2) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d expected 2", got_c.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got_c[i] !== exp_c[i]) begin
          n_bad++;
          $display("FAIL b2b_cycle%0d: got %0d expected %0d", i, got_c[i], exp_c[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h812233F4;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid();
    test_busy_req();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
